// File: rtl/if_stage_if.sv
// Bundle of the fetch-stage signals: hazard-unit and ID-stage controls,
// the instruction-memory port, and the IF/ID-facing results.
interface if_stage_if;
  logic        pc_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic [31:0] pc_plus4_out;
  logic [31:0] inst_out;
  logic        if_id_write;
  logic        if_flush;
  logic [31:0] fetch_count;

  // Surrounding pipeline / memory side
  modport master (
    output pc_write, branch_taken, branch_target, jump, jump_target,
           imem_rdata, imem_ready,
    input  imem_addr, pc_plus4_out, inst_out, if_id_write, if_flush,
           fetch_count
  );

  // Fetch stage side
  modport slave (
    input  pc_write, branch_taken, branch_target, jump, jump_target,
           imem_rdata, imem_ready,
    output imem_addr, pc_plus4_out, inst_out, if_id_write, if_flush,
           fetch_count
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, picks the next PC (sequential,
// branch, jump), remembers redirects that arrive during a stall, and
// drives the IF/ID write-enable / flush controls plus a fetch counter.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst,
  if_stage_if.slave bus
);

  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic        advance;
  logic        redirect_now;
  logic [31:0] target_now;
  logic [31:0] pc_plus4;

  // Jump wins over branch; low address bits are dropped so the PC stays
  // word aligned no matter what the ID stage hands us.
  assign advance      = bus.pc_write & bus.imem_ready;
  assign redirect_now = bus.jump | bus.branch_taken;
  assign target_now   = bus.jump ? {bus.jump_target[31:2], 2'b00}
                                 : {bus.branch_target[31:2], 2'b00};
  assign pc_plus4     = pc_q + 32'd4;

  // Next-state selection for PC, pending redirect and fetch counter
  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    fetch_count_d = fetch_count_q;
    if (advance) begin
      if (redirect_now)
        pc_d = target_now;
      else if (pend_valid_q)
        pc_d = pend_target_q;
      else
        pc_d = pc_plus4;
      // A live redirect supersedes anything pending, so pending always drops
      pend_valid_d  = 1'b0;
      fetch_count_d = fetch_count_q + 32'd1;
    end else if (redirect_now) begin
      // Latest redirect seen during the stall is the one that matters
      pend_valid_d  = 1'b1;
      pend_target_d = target_now;
    end
  end

  // State registers; reset discards any pending redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0000_0000;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Outputs are pure functions of current inputs and state. The flush
  // squashes the wrong-path slot on a redirect and inserts a bubble while
  // memory is not ready; a plain stall freezes IF/ID without flushing.
  assign bus.imem_addr    = pc_q;
  assign bus.pc_plus4_out = pc_plus4;
  assign bus.inst_out     = bus.imem_rdata;
  assign bus.if_id_write  = bus.pc_write;
  assign bus.if_flush     = (advance & (redirect_now | pend_valid_q)) |
                            (bus.pc_write & ~bus.imem_ready);
  assign bus.fetch_count  = fetch_count_q;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. Holds the PC, drives the instruction-memory address, selects next PC (sequential, branch, jump), and produces the PC+4/instruction pair plus the write-enable and flush controls consumed by IF/ID. It also keeps redirects that arrive while fetch is stalled, so they are not lost, and counts retired fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_write  input  1  from hazard unit; 1 = pipeline may advance, 0 = load-use stall.
- branch_taken  input  1  from ID stage; resolved taken branch this cycle.
- branch_target  input  32  branch destination.
- jump  input  1  from ID stage; jump this cycle.
- jump_target  input  32  jump destination.
- imem_rdata  input  32  instruction word at imem_addr.
- imem_ready  input  1  imem_rdata valid this cycle.
- imem_addr  output  32  current PC.
- pc_plus4_out  output  32  PC+4, to IF/ID pc_plus4 input.
- inst_out  output  32  equals imem_rdata, to IF/ID instruction input.
- if_id_write  output  1  to IF/ID write enable.
- if_flush  output  1  to IF/ID flush.
- fetch_count  output  32  number of advances since reset.

## Operation
- Registers: pc (32), pend_valid (1), pend_target (32), fetch_count (32).
- advance = pc_write & imem_ready.
- redirect_now = jump | branch_taken; target_now = jump ? jump_target : branch_target (jump has priority when both asserted).
- Targets have bits [1:0] forced to 2'b00 before use.
- Next-PC priority when advance=1: redirect_now -> target_now; else pend_valid -> pend_target; else pc+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
- advance=0: pc holds.
- Pending capture when advance=0 and redirect_now=1: pend_valid<=1, pend_target<=target_now. A newer redirect during the same stall overwrites pend_target.
- Pending clear: pend_valid<=0 on any advance. It is consumed or superseded by redirect_now.
- if_id_write = pc_write. A stall freezes IF/ID, including the branch instruction held in ID, so it is never flushed while stalled.
- if_flush = (advance & (redirect_now | pend_valid)) | (pc_write & ~imem_ready). The first term squashes the wrong-path fetch; the second inserts a NOP bubble on a memory wait.
- fetch_count increments by 1 on every advance and wraps at 2^32.
- Combinational outputs: imem_addr=pc, pc_plus4_out=pc+4, inst_out=imem_rdata.

## Timing
- Reset values (asynchronous, immediate): pc=RESET_PC, pend_valid=0, pend_target=0, fetch_count=0. Hence imem_addr=RESET_PC and pc_plus4_out=RESET_PC+4.
- rst asserted mid-stall or mid-redirect discards the pending redirect. The first fetch after rst deasserts is at RESET_PC.
- Redirect latency: target appears on imem_addr the cycle after the advancing edge. There is 1 wrong-path slot, squashed by if_flush in the same cycle.
- Stalled redirect: applied on the first advancing edge after capture. if_flush is asserted in that cycle.
- pc_write=1 with imem_ready=0: pc holds, IF/ID receives a zero instruction. Each further wait cycle inserts one more bubble.
- pc_write=0 with imem_ready=0: everything holds, and if_flush=0.
- Every control output is a pure function of current inputs and registers; there are no extra pipeline delays.

## Test plan
- Reset with RESET_PC=32'h0000_0040, then 3 cycles of pc_write=1, imem_ready=1 -> imem_addr goes 0x40, 0x44, 0x48, 0x4C; fetch_count=3; if_flush=0 throughout.
- At pc=0x10, branch_taken=1, branch_target=0x103 -> if_flush=1 that cycle; next imem_addr=0x100; pc_plus4_out=0x104.
- Jump and branch in the same cycle, with jump_target=0x200 and branch_target=0x300 -> next pc=0x200.
- pc_write=0 for 2 cycles with branch_taken=1 (target 0x80) in the first -> pc holds and if_flush=0. On release, if_flush=1, next pc=0x80, pend_valid clears.
- imem_ready=0 for 3 cycles with pc_write=1 -> pc holds, if_flush=1 for 3 cycles, if_id_write=1, fetch_count unchanged. It then resumes at pc+4.
- pc=32'hFFFF_FFFC, advance -> pc=0. Separately, assert rst during a pending redirect -> pc=RESET_PC and the redirect is never applied.
